// File: rtl/az_seq_pkg.sv
// ----------------------------------------------------------------------------
// az_seq_pkg
//
// Shared definitions for the auto-zero acquisition controller:
//   - 4-bit FSM state codes. These same codes appear on monitor[7:4], so a
//     logic analyser trace can be decoded with this table.
//   - Pre-charge switch polarity (SIGNAL / BOOT).
//   - Default "all switches open" AZ mux code.
//   - Bit positions inside the 8-bit debug monitor bus.
//   - Small helpers that classify states.
// ----------------------------------------------------------------------------
package az_seq_pkg;

  // FSM state encoding; IDLE is all-zero so a reset monitor reads 0.
  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_PROTECT   = 4'd1;
  localparam logic [3:0] ST_SETTLE    = 4'd2;
  localparam logic [3:0] ST_SAMPLE_HI = 4'd3;
  localparam logic [3:0] ST_WAIT_HI   = 4'd4;
  localparam logic [3:0] ST_REPROTECT = 4'd5;
  localparam logic [3:0] ST_SAMPLE_LO = 4'd6;
  localparam logic [3:0] ST_WAIT_LO   = 4'd7;
  localparam logic [3:0] ST_CHECK     = 4'd8;

  // Pre-charge switch drive levels.
  localparam logic SW_PC_SIGNAL = 1'b1;
  localparam logic SW_PC_BOOT   = 1'b0;

  // AZ mux code with every switch open.
  localparam logic [3:0] AZMUX_OFF_CODE = 4'b0000;

  // Debug monitor bit positions.
  localparam int MON_AZMUX_HI  = 0;
  localparam int MON_PC_SIGNAL = 1;
  localparam int MON_ADC_START = 2;
  localparam int MON_WAITING   = 3;
  localparam int MON_STATE_LSB = 4;

  // True in the two states that hold until the ADC reports end of conversion.
  function automatic logic is_wait_state(input logic [3:0] st);
    return (st == ST_WAIT_HI) || (st == ST_WAIT_LO);
  endfunction

  // True in the two ADC sample windows.
  function automatic logic is_sample_state(input logic [3:0] st);
    return (st == ST_SAMPLE_HI) || (st == ST_SAMPLE_LO);
  endfunction

  // True in the three pre-charge phases that last PRECHARGE_CYCLES.
  function automatic logic is_precharge_state(input logic [3:0] st);
    return (st == ST_PROTECT) || (st == ST_SETTLE) || (st == ST_REPROTECT);
  endfunction

endpackage

// File: rtl/az_sequence_ctl_phase_timer.sv
// ----------------------------------------------------------------------------
// phase_timer
//
// 32-bit loadable down-counter that measures the length of one FSM phase.
// Loading N makes `expired` assert on the N-th cycle after the load edge, so
// the owning phase lasts exactly N cycles when the FSM leaves on `expired`.
// A load of 0 behaves like a load of 1 (the phase still lasts one cycle).
//
// Ports:
//   clk     in   rising-edge clock
//   reset   in   asynchronous reset, active low
//   load    in   start a new phase measurement (wins over counting)
//   value   in   phase length in cycles, sampled while load is high
//   expired out  high for exactly one cycle, the last cycle of the phase
// ----------------------------------------------------------------------------
module phase_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] value,
  output logic        expired
);

  logic [31:0] count_q, count_d;
  logic        active_q, active_d;

  // The count reaches 1 on the final cycle; active drops afterwards so that
  // expired can never fire twice for one load.
  always_comb begin
    count_d  = count_q;
    active_d = active_q;
    if (load) begin
      count_d  = (value == 32'd0) ? 32'd1 : value;
      active_d = 1'b1;
    end else if (active_q) begin
      count_d = count_q - 32'd1;
      if (count_q == 32'd1) begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q  <= 32'd0;
      active_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      active_q <= active_d;
    end
  end

  assign expired = active_q && (count_q == 32'd1);

endmodule

// File: rtl/az_sequence_ctl.sv
// ----------------------------------------------------------------------------
// az_sequence_ctl
//
// Auto-zero acquisition controller for the DMM front end. Drives the
// pre-charge switch and AZ mux through
//   PROTECT -> SETTLE -> SAMPLE_HI -> WAIT_HI -> REPROTECT -> SAMPLE_LO
//   -> WAIT_LO -> CHECK -> (SETTLE | IDLE)
// handshaking each sample window with the ADC and counting hi/lo pairs.
//
// Optional feature macro: AZ_SEQ_TIMEOUT_EN
//   When defined, a WAIT state that sees no adc_done for TIMEOUT_CYCLES
//   aborts the run, sets the sticky err_timeout output and returns to IDLE.
//   When undefined, WAIT states wait forever and err_timeout does not exist.
//
// Ports:
//   clk                 in   rising-edge clock
//   reset               in   asynchronous reset, active low
//   start               in   one-cycle pulse, begins a run from IDLE
//   stop                in   level, finishes the current pair then idles
//   azmux_lo_val[3:0]   in   AZ mux code for the lo sample (latched at start)
//   clk_sample_duration in   sample window length (latched at start)
//   sample_target[15:0] in   pairs to acquire, 0 = continuous (latched)
//   adc_done            in   one-cycle end-of-conversion pulse
//   sw_pc_ctl           out  1 = SIGNAL, 0 = BOOT
//   azmux[3:0]          out  AZ mux select
//   adc_start           out  one-cycle pulse opening each sample window
//   adc_phase_hi        out  1 while the hi sample is acquired/converted
//   busy                out  state is not IDLE
//   seq_done            out  one-cycle pulse on the first IDLE cycle
//   sample_count[15:0]  out  completed pairs in this run (saturating)
//   err_timeout         out  sticky ADC timeout flag (macro only)
//   led0                out  high during the hi window
//   monitor[7:0]        out  debug: [0] azmux at hi, [1] pc at SIGNAL,
//                            [2] adc_start, [3] waiting, [7:4] state
//
// Every output is a flop whose next value is decoded from the next state,
// so outputs track the state register without any input-to-output path.
// ----------------------------------------------------------------------------
module az_sequence_ctl
  import az_seq_pkg::*;
#(
  parameter int unsigned PRECHARGE_CYCLES = 10000,
  parameter logic [3:0]  AZMUX_HI_VAL     = 4'b1000,
  parameter logic [3:0]  AZMUX_OFF        = AZMUX_OFF_CODE
`ifdef AZ_SEQ_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES   = 2000000
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [3:0]  azmux_lo_val,
  input  logic [31:0] clk_sample_duration,
  input  logic [15:0] sample_target,
  input  logic        adc_done,
  output logic        sw_pc_ctl,
  output logic [3:0]  azmux,
  output logic        adc_start,
  output logic        adc_phase_hi,
  output logic        busy,
  output logic        seq_done,
  output logic [15:0] sample_count,
`ifdef AZ_SEQ_TIMEOUT_EN
  output logic        err_timeout,
`endif
  output logic        led0,
  output logic [7:0]  monitor
);

  localparam logic [31:0] PRECHARGE_LEN = 32'(PRECHARGE_CYCLES);

  // FSM and latched run configuration
  logic [3:0]  state_q, state_d;
  logic [3:0]  lo_q, lo_d;
  logic [31:0] dur_q, dur_d;
  logic [15:0] target_q, target_d;
  logic [15:0] count_q, count_d;

  // Shared phase timer
  logic        timer_load;
  logic [31:0] timer_value;
  logic        timer_expired;

  // Registered outputs
  logic        sw_pc_ctl_q, sw_pc_ctl_d;
  logic [3:0]  azmux_q, azmux_d;
  logic        adc_start_q, adc_start_d;
  logic        adc_phase_hi_q, adc_phase_hi_d;
  logic        busy_q, busy_d;
  logic        seq_done_q, seq_done_d;
  logic        led0_q, led0_d;
  logic [7:0]  monitor_q, monitor_d;

  logic        timeout_hit;

  phase_timer u_phase_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (timer_load),
    .value   (timer_value),
    .expired (timer_expired)
  );

`ifdef AZ_SEQ_TIMEOUT_EN
  // A limit of 0 cannot be honoured literally; it aborts on the first
  // WAIT cycle that has no adc_done, exactly like a limit of 1.
  localparam logic [31:0] TIMEOUT_LIMIT =
    (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] to_cnt_q, to_cnt_d;
  logic        err_q, err_d;

  // to_cnt_q counts WAIT cycles already spent without adc_done; the abort
  // fires on the TIMEOUT_CYCLES-th consecutive empty cycle.
  assign timeout_hit = is_wait_state(state_q) && !adc_done &&
                       (to_cnt_q == TIMEOUT_LIMIT);

  // The counter restarts on every state change so WAIT_HI and WAIT_LO each
  // get their own full budget.
  always_comb begin
    to_cnt_d = 32'd0;
    if (is_wait_state(state_q) && (state_d == state_q)) begin
      to_cnt_d = to_cnt_q + 32'd1;
    end
  end

  // Sticky error: cleared only by an accepted start (or reset).
  always_comb begin
    err_d = err_q;
    if ((state_q == ST_IDLE) && start) begin
      err_d = 1'b0;
    end else if (timeout_hit) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt_q <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end

  assign err_timeout = err_q;
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state logic. adc_done only matters in the WAIT states, including
  // their very first cycle; start is only honoured in IDLE.
  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    dur_d    = dur_q;
    target_d = target_q;
    count_d  = count_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          lo_d     = azmux_lo_val;
          dur_d    = clk_sample_duration;
          target_d = sample_target;
          count_d  = 16'd0;
          state_d  = ST_PROTECT;
        end
      end
      ST_PROTECT:   if (timer_expired) state_d = ST_SETTLE;
      ST_SETTLE:    if (timer_expired) state_d = ST_SAMPLE_HI;
      ST_SAMPLE_HI: if (timer_expired) state_d = ST_WAIT_HI;
      ST_WAIT_HI: begin
        if (adc_done) begin
          state_d = ST_REPROTECT;
        end else if (timeout_hit) begin
          state_d = ST_IDLE;
        end
      end
      ST_REPROTECT: if (timer_expired) state_d = ST_SAMPLE_LO;
      ST_SAMPLE_LO: if (timer_expired) state_d = ST_WAIT_LO;
      ST_WAIT_LO: begin
        if (adc_done) begin
          // Saturate rather than wrap; continuous runs keep going.
          if (count_q != 16'hFFFF) begin
            count_d = count_q + 16'd1;
          end
          state_d = ST_CHECK;
        end else if (timeout_hit) begin
          state_d = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (stop || ((target_q != 16'd0) && (count_q == target_q))) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SETTLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The timer is (re)loaded on the edge that enters a timed phase, so its
  // first counting cycle is the first cycle of that phase.
  always_comb begin
    timer_load  = 1'b0;
    timer_value = PRECHARGE_LEN;
    if (state_d != state_q) begin
      if (is_precharge_state(state_d)) begin
        timer_load  = 1'b1;
        timer_value = PRECHARGE_LEN;
      end else if (is_sample_state(state_d)) begin
        timer_load  = 1'b1;
        timer_value = dur_q;
      end
    end
  end

  // Output decode from the next state. The mux only ever changes on an
  // edge where the pre-charge switch is (or becomes) BOOT: the hi code is
  // set up in SETTLE before SIGNAL is applied, and SIGNAL is dropped in
  // REPROTECT before the lo code is selected. The lo window therefore
  // stays at BOOT.
  always_comb begin
    sw_pc_ctl_d    = SW_PC_BOOT;
    azmux_d        = AZMUX_OFF;
    adc_phase_hi_d = 1'b0;
    led0_d         = 1'b0;
    case (state_d)
      ST_IDLE: begin
        sw_pc_ctl_d = SW_PC_BOOT;
        azmux_d     = AZMUX_OFF;
      end
      ST_PROTECT: azmux_d = lo_d;
      ST_SETTLE:  azmux_d = AZMUX_HI_VAL;
      ST_SAMPLE_HI, ST_WAIT_HI: begin
        sw_pc_ctl_d    = SW_PC_SIGNAL;
        azmux_d        = AZMUX_HI_VAL;
        adc_phase_hi_d = 1'b1;
        led0_d         = 1'b1;
      end
      ST_REPROTECT: azmux_d = AZMUX_HI_VAL;
      ST_SAMPLE_LO, ST_WAIT_LO, ST_CHECK: azmux_d = lo_d;
      default: azmux_d = AZMUX_OFF;
    endcase

    adc_start_d = (state_d != state_q) && is_sample_state(state_d);
    busy_d      = (state_d != ST_IDLE);
    seq_done_d  = (state_d == ST_IDLE) && (state_q != ST_IDLE);

    monitor_d                              = 8'd0;
    monitor_d[MON_AZMUX_HI]                = (azmux_d == AZMUX_HI_VAL);
    monitor_d[MON_PC_SIGNAL]               = (sw_pc_ctl_d == SW_PC_SIGNAL);
    monitor_d[MON_ADC_START]               = adc_start_d;
    monitor_d[MON_WAITING]                 = is_wait_state(state_d);
    monitor_d[MON_STATE_LSB +: 4]          = state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      lo_q           <= 4'd0;
      dur_q          <= 32'd0;
      target_q       <= 16'd0;
      count_q        <= 16'd0;
      sw_pc_ctl_q    <= SW_PC_BOOT;
      azmux_q        <= AZMUX_OFF;
      adc_start_q    <= 1'b0;
      adc_phase_hi_q <= 1'b0;
      busy_q         <= 1'b0;
      seq_done_q     <= 1'b0;
      led0_q         <= 1'b0;
      monitor_q      <= 8'd0;
    end else begin
      state_q        <= state_d;
      lo_q           <= lo_d;
      dur_q          <= dur_d;
      target_q       <= target_d;
      count_q        <= count_d;
      sw_pc_ctl_q    <= sw_pc_ctl_d;
      azmux_q        <= azmux_d;
      adc_start_q    <= adc_start_d;
      adc_phase_hi_q <= adc_phase_hi_d;
      busy_q         <= busy_d;
      seq_done_q     <= seq_done_d;
      led0_q         <= led0_d;
      monitor_q      <= monitor_d;
    end
  end

  assign sw_pc_ctl    = sw_pc_ctl_q;
  assign azmux        = azmux_q;
  assign adc_start    = adc_start_q;
  assign adc_phase_hi = adc_phase_hi_q;
  assign busy         = busy_q;
  assign seq_done     = seq_done_q;
  assign sample_count = count_q;
  assign led0         = led0_q;
  assign monitor      = monitor_q;

endmodule

// File: tb/tb_az_sequence_ctl.sv
// ----------------------------------------------------------------------------
// tb_az_sequence_ctl
//
// Directed bench for az_sequence_ctl with a small scoreboard: each run pushes
// the sample windows (phase, mux code) and sample_count values it should
// produce; a negedge checker pops them as adc_start pulses and count
// increments appear. The checker also measures phase lengths and watches
// that the mux only moves while the pre-charge switch is at BOOT.
// Build with +define+AZ_SEQ_TIMEOUT_EN to exercise the timeout abort.
// ----------------------------------------------------------------------------
module tb_az_sequence_ctl;

  localparam int         PRE     = 4;
  localparam int         TMO     = 50;
  localparam int         BOUND   = 3000;
  localparam logic [3:0] HI_VAL  = 4'b1000;
  localparam logic [3:0] OFF_VAL = 4'b0000;

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_PROTECT   = 4'd1;
  localparam logic [3:0] S_SETTLE    = 4'd2;
  localparam logic [3:0] S_SAMPLE_HI = 4'd3;
  localparam logic [3:0] S_WAIT_HI   = 4'd4;
  localparam logic [3:0] S_REPROTECT = 4'd5;
  localparam logic [3:0] S_SAMPLE_LO = 4'd6;
  localparam logic [3:0] S_WAIT_LO   = 4'd7;
  localparam logic [3:0] S_CHECK     = 4'd8;

  typedef struct {
    logic       phase_hi;
    logic [3:0] mux;
  } win_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic        stop;
  logic [3:0]  azmux_lo_val;
  logic [31:0] clk_sample_duration;
  logic [15:0] sample_target;
  logic        adc_done;
  logic        adc_auto_done;
  logic        adc_manual;
  logic        sw_pc_ctl;
  logic [3:0]  azmux;
  logic        adc_start;
  logic        adc_phase_hi;
  logic        busy;
  logic        seq_done;
  logic [15:0] sample_count;
  logic        led0;
  logic [7:0]  monitor;
`ifdef AZ_SEQ_TIMEOUT_EN
  logic        err_timeout;
`endif

  int n_compared   = 0;
  int n_mismatched = 0;

  win_t        exp_win_q[$];
  logic [15:0] exp_cnt_q[$];
  int          exp_dur        = 1;
  int          adc_delay      = 3;
  logic        adc_auto       = 1'b1;
  int          wait_cnt       = 0;
  int          seq_done_seen  = 0;
  int          adc_start_seen = 0;
  logic [3:0]  prev_state     = 4'd0;
  int          state_len      = 0;
  logic [3:0]  prev_azmux     = 4'd0;
  logic [15:0] prev_count     = 16'd0;

  assign adc_done = adc_auto_done | adc_manual;

  az_sequence_ctl #(
    .PRECHARGE_CYCLES (PRE),
    .AZMUX_HI_VAL     (HI_VAL),
    .AZMUX_OFF        (OFF_VAL)
`ifdef AZ_SEQ_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES   (TMO)
`endif
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .start               (start),
    .stop                (stop),
    .azmux_lo_val        (azmux_lo_val),
    .clk_sample_duration (clk_sample_duration),
    .sample_target       (sample_target),
    .adc_done            (adc_done),
    .sw_pc_ctl           (sw_pc_ctl),
    .azmux               (azmux),
    .adc_start           (adc_start),
    .adc_phase_hi        (adc_phase_hi),
    .busy                (busy),
    .seq_done            (seq_done),
    .sample_count        (sample_count),
`ifdef AZ_SEQ_TIMEOUT_EN
    .err_timeout         (err_timeout),
`endif
    .led0                (led0),
    .monitor             (monitor)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // ADC model: answers adc_delay cycles after a WAIT state is entered.
  initial begin
    adc_auto_done = 1'b0;
    forever begin
      @(negedge clk);
      if (reset && adc_auto && monitor[3]) begin
        adc_auto_done = (wait_cnt == adc_delay);
        wait_cnt++;
      end else begin
        adc_auto_done = 1'b0;
        wait_cnt      = 0;
      end
    end
  end

  // Scoreboard and protocol checker, sampling on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      prev_state = S_IDLE;
      state_len  = 0;
      prev_azmux = azmux;
      prev_count = sample_count;
    end else begin
      if (azmux !== prev_azmux) begin
        checkOutput("pc_boot_on_azmux_change", {31'd0, sw_pc_ctl}, 32'd0);
      end
      prev_azmux = azmux;

      if (adc_start) begin
        adc_start_seen++;
        checkOutput("mon_adc_start", {31'd0, monitor[2]}, 32'd1);
        checkOutput("adc_start_expected", {31'd0, exp_win_q.size() != 0}, 32'd1);
        if (exp_win_q.size() != 0) begin
          win_t w;
          w = exp_win_q.pop_front();
          checkOutput("win_phase_hi", {31'd0, adc_phase_hi}, {31'd0, w.phase_hi});
          checkOutput("win_azmux", {28'd0, azmux}, {28'd0, w.mux});
        end
      end

      if (seq_done) seq_done_seen++;

      if ((sample_count != prev_count) && (sample_count != 16'd0)) begin
        checkOutput("count_expected", {31'd0, exp_cnt_q.size() != 0}, 32'd1);
        if (exp_cnt_q.size() != 0) begin
          checkOutput("sample_count_step", {16'd0, sample_count},
                      {16'd0, exp_cnt_q.pop_front()});
        end
      end
      prev_count = sample_count;

      if (monitor[7:4] != prev_state) begin
        if ((prev_state == S_SAMPLE_HI) || (prev_state == S_SAMPLE_LO)) begin
          checkOutput("sample_len", state_len, exp_dur);
        end else if ((prev_state == S_PROTECT) || (prev_state == S_SETTLE) ||
                     (prev_state == S_REPROTECT)) begin
          checkOutput("precharge_len", state_len, PRE);
        end
        state_len = 1;
      end else begin
        state_len++;
      end
      prev_state = monitor[7:4];
    end
  end

  task automatic pushPairs(input logic [3:0] lo, input int pairs, input int first_count);
    for (int i = 0; i < pairs; i++) begin
      exp_win_q.push_back('{1'b1, HI_VAL});
      exp_win_q.push_back('{1'b0, lo});
      exp_cnt_q.push_back(16'(first_count + i));
    end
  endtask

  // Drives one start pulse from IDLE; returns on the negedge after the edge
  // that accepted it.
  task automatic applyStimulus(input logic [3:0] lo, input int dur, input int target);
    azmux_lo_val        = lo;
    clk_sample_duration = 32'(dur);
    sample_target       = 16'(target);
    exp_dur             = (dur == 0) ? 1 : dur;
    start               = 1'b1;
    @(negedge clk);
    start               = 1'b0;
  endtask

  task automatic waitState(input logic [3:0] code, input string tag);
    int n;
    n = 0;
    while ((monitor[7:4] != code) && (n < BOUND)) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, {28'd0, monitor[7:4]}, {28'd0, code});
  endtask

  task automatic waitSeqDone(input string tag, output int waited);
    waited = 0;
    while ((seq_done !== 1'b1) && (waited < BOUND)) begin
      @(negedge clk);
      waited++;
    end
    checkOutput(tag, {31'd0, seq_done}, 32'd1);
  endtask

  task automatic checkDrained(input string tag);
    checkOutput({tag, "_win_drained"}, exp_win_q.size(), 0);
    checkOutput({tag, "_cnt_drained"}, exp_cnt_q.size(), 0);
  endtask

  initial begin
    int waited;
    int sd0;
    int as0;
    reset               = 1'b0;
    start               = 1'b0;
    stop                = 1'b0;
    azmux_lo_val        = 4'd0;
    clk_sample_duration = 32'd0;
    sample_target       = 16'd0;
    adc_manual          = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_sw_pc", {31'd0, sw_pc_ctl}, 32'd0);
    checkOutput("rst_azmux", {28'd0, azmux}, {28'd0, OFF_VAL});
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_outputs", {28'd0, adc_start, adc_phase_hi, seq_done, led0}, 32'd0);
    checkOutput("rst_count", {16'd0, sample_count}, 32'd0);
    checkOutput("rst_monitor", {24'd0, monitor}, 32'd0);
`ifdef AZ_SEQ_TIMEOUT_EN
    checkOutput("rst_err_timeout", {31'd0, err_timeout}, 32'd0);
`endif
    reset = 1'b1;
    @(negedge clk);

    // Two pairs, duration 10, lo 0011, ADC answers 3 cycles into WAIT
    $display("[TB] run: target=2 duration=10");
    adc_delay = 3;
    sd0 = seq_done_seen;
    as0 = adc_start_seen;
    pushPairs(4'b0011, 2, 1);
    applyStimulus(4'b0011, 10, 2);
    checkOutput("start_to_protect", {28'd0, monitor[7:4]}, {28'd0, S_PROTECT});
    checkOutput("protect_azmux", {28'd0, azmux}, 32'h3);
    checkOutput("protect_busy", {31'd0, busy}, 32'd1);
    waitSeqDone("run2_seq_done", waited);
    checkOutput("run2_idle", {28'd0, monitor[7:4]}, {28'd0, S_IDLE});
    checkOutput("run2_idle_azmux", {28'd0, azmux}, {28'd0, OFF_VAL});
    checkOutput("run2_count", {16'd0, sample_count}, 32'd2);
    repeat (3) @(negedge clk);
    checkOutput("run2_seq_done_pulses", seq_done_seen - sd0, 1);
    checkOutput("run2_adc_start_pulses", adc_start_seen - as0, 4);
    checkDrained("run2");

    // Duration 0 behaves as one-cycle windows
    $display("[TB] run: target=1 duration=0");
    pushPairs(4'b0110, 1, 1);
    applyStimulus(4'b0110, 0, 1);
    waitSeqDone("dur0_seq_done", waited);
    checkOutput("dur0_count", {16'd0, sample_count}, 32'd1);
    repeat (2) @(negedge clk);
    checkDrained("dur0");

    // Continuous mode stopped during pair 5; ADC answers on WAIT entry
    $display("[TB] run: continuous, stop in pair 5");
    adc_delay = 0;
    pushPairs(4'b0010, 5, 1);
    applyStimulus(4'b0010, 2, 0);
    waited = 0;
    while (!((sample_count == 16'd4) && (monitor[7:4] == S_SAMPLE_LO)) && (waited < BOUND)) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("pair5_lo_reached", {28'd0, monitor[7:4]}, {28'd0, S_SAMPLE_LO});
    stop = 1'b1;
    waitState(S_CHECK, "stop_check_reached");
    @(negedge clk);
    checkOutput("stop_idle_after_check", {28'd0, monitor[7:4]}, {28'd0, S_IDLE});
    checkOutput("stop_seq_done", {31'd0, seq_done}, 32'd1);
    checkOutput("stop_count", {16'd0, sample_count}, 32'd5);
    stop = 1'b0;
    repeat (2) @(negedge clk);
    checkDrained("stop");

    // start while busy is ignored
    $display("[TB] run: start while busy");
    adc_delay = 2;
    pushPairs(4'b0101, 1, 1);
    applyStimulus(4'b0101, 5, 1);
    waitState(S_SAMPLE_HI, "busy_sample_hi");
    azmux_lo_val = 4'b1111;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_start_state", {28'd0, monitor[7:4]}, {28'd0, S_SAMPLE_HI});
    checkOutput("busy_start_azmux", {28'd0, azmux}, {28'd0, HI_VAL});
    checkOutput("busy_start_count", {16'd0, sample_count}, 32'd0);
    waitSeqDone("busy_seq_done", waited);
    checkOutput("busy_final_count", {16'd0, sample_count}, 32'd1);
    repeat (2) @(negedge clk);
    checkDrained("busy");

    // Reset in the middle of SAMPLE_HI of pair 2
    $display("[TB] run: reset mid SAMPLE_HI");
    pushPairs(4'b0011, 1, 1);
    exp_win_q.push_back('{1'b1, HI_VAL});
    applyStimulus(4'b0011, 10, 0);
    waited = 0;
    while (!((sample_count == 16'd1) && (monitor[7:4] == S_SAMPLE_HI)) && (waited < BOUND)) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    checkOutput("hi_window_bits", {27'd0, monitor[1:0], sw_pc_ctl, adc_phase_hi, led0}, 32'h1F);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midrst_sw_pc", {31'd0, sw_pc_ctl}, 32'd0);
    checkOutput("midrst_azmux", {28'd0, azmux}, {28'd0, OFF_VAL});
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_count", {16'd0, sample_count}, 32'd0);
    checkOutput("midrst_monitor", {24'd0, monitor}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    checkDrained("midrst");

    // adc_done during SETTLE only, then the ADC goes silent
    $display("[TB] run: adc_done lost");
    adc_auto = 1'b0;
    exp_win_q.push_back('{1'b1, HI_VAL});
    applyStimulus(4'b0011, 3, 1);
    waitState(S_SETTLE, "lost_settle");
    adc_manual = 1'b1;
    @(negedge clk);
    adc_manual = 1'b0;
    waitState(S_WAIT_HI, "lost_wait_hi");
`ifdef AZ_SEQ_TIMEOUT_EN
    waitSeqDone("timeout_seq_done", waited);
    checkOutput("timeout_cycles", waited, TMO);
    checkOutput("timeout_err", {31'd0, err_timeout}, 32'd1);
    checkOutput("timeout_azmux", {28'd0, azmux}, {28'd0, OFF_VAL});
    checkOutput("timeout_sw_pc", {31'd0, sw_pc_ctl}, 32'd0);
    checkOutput("timeout_count", {16'd0, sample_count}, 32'd0);
    repeat (2) @(negedge clk);
    checkDrained("timeout");
    adc_auto  = 1'b1;
    adc_delay = 1;
    pushPairs(4'b0011, 1, 1);
    applyStimulus(4'b0011, 2, 1);
    checkOutput("start_clears_err", {31'd0, err_timeout}, 32'd0);
    waitSeqDone("after_timeout_seq_done", waited);
    checkOutput("after_timeout_count", {16'd0, sample_count}, 32'd1);
    repeat (2) @(negedge clk);
    checkDrained("after_timeout");
`else
    repeat (100) @(negedge clk);
    checkOutput("stuck_wait_hi", {28'd0, monitor[7:4]}, {28'd0, S_WAIT_HI});
    checkOutput("stuck_busy", {31'd0, busy}, 32'd1);
    checkOutput("stuck_count", {16'd0, sample_count}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkDrained("stuck");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/az_sequence_ctl.md
# az_sequence_ctl

Auto-zero acquisition controller for the DMM front end. Owns the pre-charge (PC) switch and the AZ mux and drives them through the protect → settle → hi-sample → re-protect → lo-sample cycle. It handshakes each sample window with the ADC and counts completed hi/lo pairs. It sits between the register bank (configuration, start/stop) and the analog switch drivers and ADC sequencer.

## Interface
Parameters:
- `PRECHARGE_CYCLES`, default 10000. Protect and settle phase length in clk cycles (500 µs at 20 MHz).
- `AZMUX_HI_VAL`, default 4'b1000. AZ mux code selecting PC-OUT (hi).
- `AZMUX_OFF`, default 4'b0000. AZ mux code for all switches open.
- `TIMEOUT_CYCLES`, default 2000000. `adc_done` wait limit; used only with `AZ_SEQ_TIMEOUT_EN`.

Ports:
- `clk` in 1. Single clock; all logic is on the rising edge.
- `reset` in 1. Asynchronous, active-low.
- `start` in 1. Single-cycle pulse; begins a run when idle.
- `stop` in 1. Level; completes the current pair, then returns to idle.
- `azmux_lo_val` in 4. AZ mux code for the lo measurement; sampled at `start`.
- `clk_sample_duration` in 32. Sample window length in cycles; sampled at `start`.
- `sample_target` in 16. Number of pairs to acquire, 0 = continuous; sampled at `start`.
- `adc_done` in 1. Single-cycle pulse from the ADC marking the end of conversion.
- `sw_pc_ctl` out 1. 1 = SIGNAL, 0 = BOOT.
- `azmux` out 4. AZ mux select.
- `adc_start` out 1. Single-cycle pulse at the start of each sample window.
- `adc_phase_hi` out 1. 1 during the hi window, 0 during the lo window.
- `busy` out 1. High whenever the state is not IDLE.
- `seq_done` out 1. Single-cycle pulse on return to IDLE.
- `sample_count` out 16. Number of completed pairs in the current run.
- `err_timeout` out 1. Sticky; cleared by `start` or reset. Present only with the macro.
- `led0` out 1. High during the hi window.
- `monitor` out 8. Debug: [0] azmux at hi, [1] pc at SIGNAL, [2] adc_start, [3] waiting for adc_done, [7:4] state code.

## Operation
- States: IDLE, PROTECT, SETTLE, SAMPLE_HI, WAIT_HI, REPROTECT, SAMPLE_LO, WAIT_LO, CHECK.
- IDLE:
  - `sw_pc_ctl`=BOOT, `azmux`=AZMUX_OFF.
  - On `start`: latch the config inputs, clear `sample_count`, go to PROTECT.
- PROTECT: BOOT, `azmux`=latched lo value, for PRECHARGE_CYCLES.
- SETTLE: `azmux`=AZMUX_HI_VAL, PC still BOOT, for PRECHARGE_CYCLES.
- SAMPLE_HI:
  - `sw_pc_ctl`=SIGNAL; `adc_start` pulses on the first cycle; `adc_phase_hi`=1; `led0`=1.
  - Lasts `clk_sample_duration` cycles, then moves to WAIT_HI.
- WAIT_HI: hold until `adc_done`, then go to REPROTECT.
- REPROTECT: BOOT, azmux held at hi, for PRECHARGE_CYCLES.
- SAMPLE_LO:
  - `azmux`=lo value; `adc_start` pulses on the first cycle; `adc_phase_hi`=0; `led0`=0.
  - Lasts `clk_sample_duration` cycles, then moves to WAIT_LO.
- WAIT_LO: on `adc_done`, increment `sample_count` and go to CHECK.
- CHECK (one cycle):
  - Go to IDLE if `stop` is high, or if `sample_target`≠0 and `sample_count`==`sample_target`.
  - Otherwise go to SETTLE.
- Phase length rule: a load of N gives exactly N cycles in that phase. N=0 is treated as 1.
- `adc_done` outside WAIT_HI/WAIT_LO is ignored.
- `adc_done` in the same cycle that WAIT_* is entered counts.
- `start` while busy is ignored.
- `sample_count` saturates at 16'hFFFF and does not wrap. Continuous mode keeps running after saturation.
- Reset, asserted at any time:
  - State goes to IDLE.
  - `sw_pc_ctl`=0 (BOOT), `azmux`=AZMUX_OFF.
  - `adc_start`, `adc_phase_hi`, `busy`, `seq_done`, `led0`, `err_timeout` = 0.
  - `sample_count`=0, `monitor`=0.
- The PC switch must be BOOT on every cycle in which `azmux` changes value.

## Timing
- All outputs are registered. No combinational path from input to output.
- `start` to PROTECT outputs: 1 cycle.
- Minimum period per pair: 3·PRECHARGE_CYCLES (first pair only) + 2·duration + 2 + adc_done latency + 1.
- Steady state, one pair: SETTLE + SAMPLE_HI + WAIT_HI + REPROTECT + SAMPLE_LO + WAIT_LO + CHECK (1).
- `seq_done` pulses in the first IDLE cycle.
- `stop` is sampled only in CHECK. Its effect is 1 cycle after CHECK.

## Configuration
- Macro: `AZ_SEQ_TIMEOUT_EN`.
- Defined:
  - In WAIT_HI or WAIT_LO, if `adc_done` is absent for TIMEOUT_CYCLES, set `err_timeout`, drive BOOT + AZMUX_OFF, go to IDLE, and pulse `seq_done`.
  - `sample_count` is not incremented on a timeout.
- Undefined:
  - WAIT states wait indefinitely.
  - The `err_timeout` port and the timeout counter are absent.

## Structure
- Package `az_seq_pkg`: state encoding (4-bit, matches `monitor[7:4]`), SW_PC_SIGNAL=1, SW_PC_BOOT=0, AZMUX_OFF, monitor bit indices.
- Sub-module `phase_timer`:
  - 32-bit loadable down-counter with `load`, `value`, and a single-cycle `expired` output.
  - Shared by all timed phases; implements the N=0→1 rule.
- The timeout counter sits in the top level, inside the macro guard.

## Test plan
- Reset mid-SAMPLE_HI → next cycle `sw_pc_ctl`=0, `azmux`=0, `busy`=0, `sample_count`=0.
- PRECHARGE_CYCLES=4, duration=10, target=2, lo=4'b0011, `adc_done` 3 cycles after WAIT entry:
  - `adc_start` pulses 4 times.
  - `sample_count` goes 1 then 2.
  - `seq_done` pulses once.
  - Checker: `azmux` never changes while `sw_pc_ctl`=1.
- duration=0 → each sample window lasts exactly 1 cycle; pair completes normally.
- target=0 with `stop` raised during SAMPLE_LO of pair 5 → returns to IDLE after CHECK with `sample_count`=5.
- `adc_done` pulsed in SETTLE, then never again → FSM stays in WAIT_HI; with `AZ_SEQ_TIMEOUT_EN`, `err_timeout`=1 after TIMEOUT_CYCLES, then IDLE.
- `start` pulsed while busy → no restart, `sample_count` unchanged; `start` from IDLE clears `err_timeout`.
